// File: rtl/uart_rx_oversampled_if.sv
// Serial receive bundle: line input, byte holding register handshake and status.
interface uart_rx_oversampled_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    // Drives the serial line and consumes received bytes.
    modport master (
        output rx,
        output ready,
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        input  busy
    );

    // The receiver itself.
    modport slave (
        input  rx,
        input  ready,
        output data,
        output valid,
        output frame_err,
        output overrun,
        output busy
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver oversampling rx on clk; bytes land in a valid/ready
// holding register. CLKS_PER_BIT must be even and at least 4.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line idle, waiting for rx_s low
// S_START | counting to mid start bit; high there means false start
// S_DATA  | sampling 8 data bits one bit period apart, LSB first
// S_STOP  | sampling stop bit; high delivers, low flags framing error
// S_BREAK | line stuck low after a framing error; wait for it to rise
module uart_rx_oversampled #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_rx_oversampled_if.slave bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q;
    logic            rx_s_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bitidx_q, bitidx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= bus.rx;
            rx_s_q  <= sync1_q;
        end
    end

    // Next-state, bit timing and holding-register update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitidx_d    = bitidx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Consumer handshake; a delivery below in the same cycle re-sets valid.
        if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_TC) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_DATA;
                        bitidx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_TC) begin
                    cnt_d    = '0;
                    shift_d  = {rx_s_q, shift_q[7:1]};
                    bitidx_d = bitidx_q + 3'd1;
                    if (bitidx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_TC) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        // Return to IDLE right away so a start edge in the next cycle is caught.
                        state_d = S_IDLE;
                        if (!valid_q || bus.ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bitidx_q    <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitidx_q    <= bitidx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: directed scenarios plus randomized frames
// checked against an expected-byte queue and event counts.
module tb_uart_rx_oversampled;

    localparam int CPB = 4;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;

    uart_rx_oversampled_if u_if();

    uart_rx_oversampled #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; the next edge has this index.
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Observed-event log, sampled mid-cycle.
    logic       valid_prev = 1'b0;
    int         rise_q[$];
    logic [7:0] acc_q[$];
    int         fe_cnt = 0, ov_cnt = 0, both_cnt = 0, valid_hi = 0;
    int         fe_edge = -1, ov_edge = -1;

    always @(negedge clk) begin
        #1;
        if (u_if.valid && !valid_prev) rise_q.push_back(edge_cnt - 1);
        if (u_if.valid) valid_hi++;
        if (u_if.valid && u_if.ready) acc_q.push_back(u_if.data);
        if (u_if.frame_err) begin fe_cnt++; fe_edge = edge_cnt - 1; end
        if (u_if.overrun) begin ov_cnt++; ov_edge = edge_cnt - 1; end
        if (u_if.frame_err && u_if.overrun) both_cnt++;
        valid_prev = u_if.valid;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        u_if.rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    // Caller must be at a falling edge. t0 is the index of the first edge seeing rx low.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t0);
        t0 = edge_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!u_if.valid && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 32'(u_if.valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t_a, t_b, t;
        int         fe0, ov0, acc0, vh0, exp_fe, gap, bad;
        logic       busy_seen, good;
        logic [7:0] b;
        logic [7:0] exp_q[$];
        logic [7:0] part;

        u_if.rx    = 1'b1;
        u_if.ready = 1'b0;
        rst_n      = 1'b0;
        idle(3);
        #1;
        check("rst_valid", 32'(u_if.valid), 32'd0);
        check("rst_data", 32'(u_if.data), 32'd0);
        check("rst_busy", 32'(u_if.busy), 32'd0);
        check("rst_ferr", 32'(u_if.frame_err), 32'd0);
        check("rst_ovr", 32'(u_if.overrun), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // Two frames with ready held high: latency, single-cycle valid, data.
        u_if.ready = 1'b1;
        vh0 = valid_hi;
        send_frame(8'h55, 1'b1, t_a);
        idle(2 * CPB);
        send_frame(8'hA3, 1'b1, t_b);
        idle(3 * CPB);
        check("s1_rises", 32'(rise_q.size()), 32'd2);
        if (rise_q.size() >= 2) begin
            check("s1_lat_a", 32'(rise_q[0] - t_a), 32'(LAT));
            check("s1_lat_b", 32'(rise_q[1] - t_b), 32'(LAT));
        end
        check("s1_acc_cnt", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() >= 2) begin
            check("s1_byte_a", 32'(acc_q[0]), 32'h55);
            check("s1_byte_b", 32'(acc_q[1]), 32'hA3);
        end
        check("s1_valid_cycles", 32'(valid_hi - vh0), 32'd2);
        check("s1_ferr", 32'(fe_cnt), 32'd0);
        check("s1_ovr", 32'(ov_cnt), 32'd0);

        // Held byte waits for the consumer.
        u_if.ready = 1'b0;
        send_frame(8'h3C, 1'b1, t);
        wait_valid("s2_valid", 2 * CPB);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (!(u_if.valid === 1'b1 && u_if.data === 8'h3C)) bad++;
        end
        check("s2_hold", 32'(bad), 32'd0);
        @(negedge clk);
        u_if.ready = 1'b1;
        #1;
        check("s2_valid_on_accept", 32'(u_if.valid), 32'd1);
        @(negedge clk);
        #1;
        check("s2_cleared", 32'(u_if.valid), 32'd0);
        check("s2_acc_byte", 32'(acc_q[acc_q.size() - 1]), 32'h3C);

        // Back-to-back frames into a full holding register.
        @(negedge clk);
        u_if.ready = 1'b0;
        ov0  = ov_cnt;
        acc0 = acc_q.size();
        send_frame(8'h11, 1'b1, t_a);
        send_frame(8'h22, 1'b1, t_b);
        idle(2 * CPB);
        #1;
        check("s3_ovr_cnt", 32'(ov_cnt - ov0), 32'd1);
        check("s3_ovr_edge", 32'(ov_edge - t_b), 32'(LAT));
        check("s3_valid", 32'(u_if.valid), 32'd1);
        check("s3_data", 32'(u_if.data), 32'h11);
        @(negedge clk);
        u_if.ready = 1'b1;
        idle(3);
        check("s3_acc_cnt", 32'(acc_q.size() - acc0), 32'd1);
        check("s3_acc_byte", 32'(acc_q[acc_q.size() - 1]), 32'h11);

        // Framing error followed by a long break, then a good frame.
        fe0  = fe_cnt;
        acc0 = acc_q.size();
        vh0  = valid_hi;
        send_frame(8'h7E, 1'b0, t);
        u_if.rx = 1'b0;
        idle(50);
        #1;
        check("s4_ferr_cnt", 32'(fe_cnt - fe0), 32'd1);
        check("s4_ferr_edge", 32'(fe_edge - t), 32'(LAT));
        check("s4_no_valid", 32'(valid_hi - vh0), 32'd0);
        check("s4_busy_break", 32'(u_if.busy), 32'd1);
        @(negedge clk);
        u_if.rx = 1'b1;
        idle(2 * CPB);
        send_frame(8'h81, 1'b1, t);
        idle(3 * CPB);
        check("s4_ferr_total", 32'(fe_cnt - fe0), 32'd1);
        check("s4_acc_cnt", 32'(acc_q.size() - acc0), 32'd1);
        check("s4_acc_byte", 32'(acc_q[acc_q.size() - 1]), 32'h81);

        // Single-cycle glitch on an idle line.
        fe0  = fe_cnt;
        acc0 = acc_q.size();
        u_if.rx = 1'b0;
        @(negedge clk);
        u_if.rx = 1'b1;
        busy_seen = 1'b0;
        repeat (CPB / 2 + 2) begin
            @(negedge clk);
            #1;
            if (u_if.busy) busy_seen = 1'b1;
        end
        check("s5_busy_seen", 32'(busy_seen), 32'd1);
        check("s5_busy_clear", 32'(u_if.busy), 32'd0);
        idle(2 * CPB);
        check("s5_no_ferr", 32'(fe_cnt - fe0), 32'd0);
        check("s5_no_byte", 32'(acc_q.size() - acc0), 32'd0);

        // Reset in the middle of bit 4.
        acc0 = acc_q.size();
        part = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(part[i]);
        u_if.rx = part[4];
        idle(2);
        rst_n = 1'b0;
        #1;
        check("s6_rst_valid", 32'(u_if.valid), 32'd0);
        check("s6_rst_busy", 32'(u_if.busy), 32'd0);
        check("s6_rst_data", 32'(u_if.data), 32'd0);
        check("s6_rst_ferr", 32'(u_if.frame_err), 32'd0);
        check("s6_rst_ovr", 32'(u_if.overrun), 32'd0);
        idle(3);
        u_if.rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3 * CPB);
        check("s6_no_partial", 32'(acc_q.size() - acc0), 32'd0);
        send_frame(8'hF0, 1'b1, t);
        idle(3 * CPB);
        check("s6_acc_cnt", 32'(acc_q.size() - acc0), 32'd1);
        check("s6_acc_byte", 32'(acc_q[acc_q.size() - 1]), 32'hF0);

        // Randomized frames, gaps and bad stop bits against the expected-byte queue.
        fe0    = fe_cnt;
        acc0   = acc_q.size();
        exp_fe = 0;
        for (int k = 0; k < 24; k++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            gap  = $urandom_range(0, 3 * CPB);
            send_frame(b, good, t);
            if (good) begin
                exp_q.push_back(b);
            end else begin
                exp_fe++;
                u_if.rx = 1'b0;
                idle($urandom_range(0, 20));
                u_if.rx = 1'b1;
                gap = gap + CPB;
            end
            idle(gap);
        end
        idle(3 * CPB);
        check("rnd_ferr_cnt", 32'(fe_cnt - fe0), 32'(exp_fe));
        check("rnd_acc_cnt", 32'(acc_q.size() - acc0), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (acc0 + k < acc_q.size())
                check($sformatf("rnd_byte_%0d", k), 32'(acc_q[acc0 + k]), 32'(exp_q[k]));
        end

        check("never_both_pulses", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
